th_scan_seq: RTL and testbench
==============================

TH_SCAN_SEQ -- requirements
Module: th_scan_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: cycles allowed per handshake phase before the timeout is declared.
REQ-002 Parameter CNT_W, default 16: width of the timeout counter; TIMEOUT_CYC SHALL be less than 2^CNT_W.
REQ-003 Port CLK, input, 1: single clock, rising edge.
REQ-004 Port RST, input, 1: asynchronous, active-high reset.
REQ-005 Port Start, input, 1: one-cycle request to run a scan batch; ignored unless Busy=0.
REQ-006 Port ScanLog2, input, 2: batch size N = 2^ScanLog2 (1, 2, 4 or 8 scans); sampled when Start is accepted.
REQ-007 Port ScanDone, input, 1: completion flag from the threshold controller.
REQ-008 Port BL, input, 10: baseline from the threshold controller.
REQ-009 Port NW, input, 4: noise width from the threshold controller.
REQ-010 Port ScanStart, output, 1: scan request to the threshold controller.
REQ-011 Port Busy, output, 1: high while the batch is in progress.
REQ-012 Port Done, output, 1: one-cycle pulse when the batch ends, whether by success or by timeout.
REQ-013 Port Timeout, output, 1: sticky error flag; cleared by the next accepted Start.
REQ-014 Port BLAvg, output, 10: averaged baseline of the batch.
REQ-015 Port NWMax, output, 4: maximum NW seen in the batch.
REQ-016 Port StateOut, output, 3: current FSM state encoding.

Function
REQ-017 States and encodings: IDLE=0, ARM=1, CAPTURE=2, RELEASE=3, DONE=4, FAIL=5.
REQ-018 IDLE: on Start, clear the accumulator, NWMax working register, scan counter and Timeout, latch N, then go to ARM.
REQ-019 ARM: ScanStart=1; when ScanDone=1 go to CAPTURE; if the phase counter reaches TIMEOUT_CYC first, go to FAIL.
REQ-020 CAPTURE (one cycle): ScanStart=1; sum += BL (13-bit unsigned, no overflow possible); NWmax = max(NWmax, NW); increment the scan counter; go to RELEASE.
REQ-021 RELEASE: ScanStart=0; when ScanDone=0, go to ARM if scans remain, otherwise go to DONE; the RELEASE phase uses the same timeout rule as ARM and goes to FAIL on expiry.
REQ-022 The phase counter SHALL reset on entry to ARM and on entry to RELEASE.
REQ-023 The phase counter SHALL saturate and never wrap.
REQ-024 DONE (one cycle): BLAvg <= sum >> ScanLog2 (truncating); NWMax <= working max; Done=1; go to IDLE.
REQ-025 FAIL (one cycle): ScanStart=0; Timeout=1; Done=1; BLAvg and NWMax hold their prior values; go to IDLE.
REQ-026 Busy=1 in every state except IDLE.
REQ-027 Start while Busy=1 SHALL be ignored, with no effect.
REQ-028 Latency, N=1 with ScanDone responding in k cycles: Done asserts exactly k+4 cycles after Start, assuming ScanDone drops 1 cycle after ScanStart falls.
REQ-029 ScanDone=1 already present on entry to ARM SHALL be accepted, proceeding to CAPTURE on the next cycle.
REQ-030 Start and ScanDone asserted in the same cycle while in IDLE: Start is accepted and ScanDone is ignored.

Reset
REQ-031 RST=1 SHALL immediately force: state IDLE, ScanStart=0, Busy=0, Done=0, Timeout=0, BLAvg=0, NWMax=0, StateOut=0, and all counters and accumulators 0.
REQ-032 RST asserted mid-batch SHALL abandon the batch with no Done pulse.
REQ-033 RST SHALL be released synchronously by the system, so the first edge after release is a normal operating cycle.

Configuration
REQ-034 Macro TH_SCAN_SEQ_RETRY_EN defined: on the first timeout of a batch, the FSM SHALL drop ScanStart for 4 cycles and re-enter ARM for the same scan index.
REQ-035 With TH_SCAN_SEQ_RETRY_EN defined, a second timeout in the same batch SHALL go to FAIL.
REQ-036 With TH_SCAN_SEQ_RETRY_EN defined, StateOut SHALL be 6 during the retry gap.
REQ-037 Macro TH_SCAN_SEQ_RETRY_EN undefined: the first timeout SHALL go to FAIL, and state 6 SHALL never occur.

Verification
REQ-038 Single scan: ScanLog2=0, responder returns ScanDone 10 cycles after ScanStart with BL=0x155, NW=3 -> BLAvg=0x155, NWMax=3, Done pulses once, Timeout=0.
REQ-039 Averaging: ScanLog2=2 with BL sequence 100, 101, 102, 104 and NW sequence 2, 7, 1, 5 -> BLAvg=101 (407>>2), NWMax=7, exactly 4 ScanStart rising edges.
REQ-040 Timeout: TIMEOUT_CYC=20, ScanDone never asserts -> Timeout=1 and Done pulse after 21 ARM cycles without the macro; with the macro, a second ARM attempt precedes FAIL.
REQ-041 Reset mid-operation: RST pulsed during the third RELEASE of an 8-scan batch -> all outputs 0 and StateOut=0; a new Start then completes normally.
REQ-042 Ignored Start: Start pulsed repeatedly during Busy -> batch size and results unchanged, exactly one Done pulse.
REQ-043 Maximum BL: ScanLog2=3 with BL=1023 for all 8 scans -> sum 8184, BLAvg=1023, no overflow.

Source files
------------

// File: rtl/th_scan_seq.sv
// th_scan_seq: runs a batch of 1, 2, 4 or 8 threshold scans over the
// ScanStart/ScanDone handshake. It averages BL over the batch and tracks the
// largest NW. Each handshake phase (ARM, RELEASE) has its own timeout.
// Optional feature: define TH_SCAN_SEQ_RETRY_EN to allow one 4-cycle retry
// gap (StateOut=6) per batch. With the retry enabled, only a second timeout
// in the batch fails it.
module th_scan_seq #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [1:0] ScanLog2,
    input  logic       ScanDone,
    input  logic [9:0] BL,
    input  logic [3:0] NW,
    output logic       ScanStart,
    output logic       Busy,
    output logic       Done,
    output logic       Timeout,
    output logic [9:0] BLAvg,
    output logic [3:0] NWMax,
    output logic [2:0] StateOut
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5,
        S_RETRY   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       scan_q, scan_d;
    logic [1:0]       log2_q, log2_d;
    logic [12:0]      sum_q, sum_d;
    logic [3:0]       nwmax_q, nwmax_d;
    logic [9:0]       blavg_q, blavg_d;
    logic [3:0]       nwout_q, nwout_d;
    logic             timeout_q, timeout_d;
`ifdef TH_SCAN_SEQ_RETRY_EN
    logic             retry_q, retry_d;
    logic             from_rel_q, from_rel_d;
`endif
    logic             expired;
    logic             tmo_hit;
    logic [3:0]       scan_n;

    assign expired = (cnt_q == TMO);
    assign scan_n  = 4'd1 << log2_q;

    // Next-state, datapath updates and the timeout/retry decision
    always_comb begin
        state_d   = state_q;
        cnt_d     = expired ? cnt_q : cnt_q + CNT_ONE;   // saturating phase counter
        scan_d    = scan_q;
        log2_d    = log2_q;
        sum_d     = sum_q;
        nwmax_d   = nwmax_q;
        blavg_d   = blavg_q;
        nwout_d   = nwout_q;
        timeout_d = timeout_q;
        tmo_hit   = 1'b0;
`ifdef TH_SCAN_SEQ_RETRY_EN
        retry_d    = retry_q;
        from_rel_d = from_rel_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Start) begin
                    sum_d     = '0;
                    nwmax_d   = '0;
                    scan_d    = '0;
                    timeout_d = 1'b0;
                    log2_d    = ScanLog2;
`ifdef TH_SCAN_SEQ_RETRY_EN
                    retry_d   = 1'b0;
`endif
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (ScanDone) state_d = S_CAPTURE;
                else if (expired) tmo_hit = 1'b1;
            end
            S_CAPTURE: begin
                sum_d   = sum_q + {3'b000, BL};
                nwmax_d = (NW > nwmax_q) ? NW : nwmax_q;
                scan_d  = scan_q + 4'd1;
                cnt_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!ScanDone) begin
                    cnt_d = '0;
                    if (scan_q == scan_n) begin
                        blavg_d = 10'(sum_q >> log2_q);
                        nwout_d = nwmax_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
`ifdef TH_SCAN_SEQ_RETRY_EN
            S_RETRY: begin
                // A scan whose release timed out was already captured, so the
                // retry resumes waiting for release instead of capturing twice.
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = from_rel_q ? S_RELEASE : S_ARM;
                end
            end
`endif
            default: state_d = S_IDLE;   // DONE and FAIL last one cycle
        endcase

        if (tmo_hit) begin
`ifdef TH_SCAN_SEQ_RETRY_EN
            if (!retry_q) begin
                retry_d    = 1'b1;
                from_rel_d = (state_q == S_RELEASE);
                cnt_d      = '0;
                state_d    = S_RETRY;
            end else begin
                timeout_d = 1'b1;
                state_d   = S_FAIL;
            end
`else
            timeout_d = 1'b1;
            state_d   = S_FAIL;
`endif
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            scan_q    <= '0;
            log2_q    <= '0;
            sum_q     <= '0;
            nwmax_q   <= '0;
            blavg_q   <= '0;
            nwout_q   <= '0;
            timeout_q <= 1'b0;
`ifdef TH_SCAN_SEQ_RETRY_EN
            retry_q    <= 1'b0;
            from_rel_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            log2_q    <= log2_d;
            sum_q     <= sum_d;
            nwmax_q   <= nwmax_d;
            blavg_q   <= blavg_d;
            nwout_q   <= nwout_d;
            timeout_q <= timeout_d;
`ifdef TH_SCAN_SEQ_RETRY_EN
            retry_q    <= retry_d;
            from_rel_q <= from_rel_d;
`endif
        end
    end

    assign ScanStart = (state_q == S_ARM) || (state_q == S_CAPTURE);
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE) || (state_q == S_FAIL);
    assign Timeout   = timeout_q;
    assign BLAvg     = blavg_q;
    assign NWMax     = nwout_q;
    assign StateOut  = state_q;

endmodule

// File: tb/tb_th_scan_seq.sv
// tb_th_scan_seq: bench for th_scan_seq with TIMEOUT_CYC=20. A responder
// raises ScanDone after k ScanStart cycles and drops it one cycle after
// ScanStart falls. Batches come from a vector table and from random draws.
module tb_th_scan_seq;

    localparam int TMO = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Start = 1'b0;
    logic [1:0] ScanLog2 = 2'd0;
    logic       ScanDone;
    logic [9:0] BL;
    logic [3:0] NW;
    logic       ScanStart, Busy, Done, Timeout;
    logic [9:0] BLAvg;
    logic [3:0] NWMax;
    logic [2:0] StateOut;

    th_scan_seq #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .ScanLog2(ScanLog2),
        .ScanDone(ScanDone), .BL(BL), .NW(NW),
        .ScanStart(ScanStart), .Busy(Busy), .Done(Done), .Timeout(Timeout),
        .BLAvg(BLAvg), .NWMax(NWMax), .StateOut(StateOut)
    );

    always #5 CLK = ~CLK;

    // responder state
    bit              ren = 1'b0;
    int              rk = 1;
    logic [7:0][9:0] rbl = '0;
    logic [7:0][3:0] rnw = '0;
    int              ridx = 0;
    int              ss_cnt = 0;
    logic            prev_ss = 1'b0;
    logic            resp_sd = 1'b0;
    logic [9:0]      resp_bl = '0;
    logic [3:0]      resp_nw = '0;
    // hand-driven override
    bit              man_mode = 1'b0;
    logic            man_sd = 1'b0;
    logic [9:0]      man_bl = '0;
    logic [3:0]      man_nw = '0;

    assign ScanDone = man_mode ? man_sd : resp_sd;
    assign BL       = man_mode ? man_bl : resp_bl;
    assign NW       = man_mode ? man_nw : resp_nw;

    always @(posedge CLK) begin
        #1;
        if (RST || !Busy) begin
            ridx   = 0;
            ss_cnt = 0;
        end
        if (RST) begin
            resp_sd = 1'b0;
            prev_ss = 1'b0;
        end else if (ScanStart) begin
            ss_cnt++;
            if (ren && ss_cnt >= rk && !resp_sd) begin
                resp_sd = 1'b1;
                resp_bl = rbl[ridx % 8];
                resp_nw = rnw[ridx % 8];
                ridx++;
            end
            prev_ss = 1'b1;
        end else begin
            ss_cnt = 0;
            if (!prev_ss) resp_sd = 1'b0;
            prev_ss = 1'b0;
        end
    end

    typedef struct {
        logic [1:0]      log2;
        int              k;
        bit              spam;
        logic [7:0][9:0] bl;
        logic [7:0][3:0] nw;
        int              exp_avg;
        int              exp_max;
        int              exp_lat;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   done_total = 0;
    int   rise_total = 0;
    logic ss_prev_m = 1'b0;
    int   last_avg = 0;
    int   last_max = 0;
    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (Done) done_total++;
        if (ScanStart && !ss_prev_m) rise_total++;
        ss_prev_m = ScanStart;
    endtask

    // Reference: average and max over the first N entries; each scan costs
    // k ARM cycles, one CAPTURE and two RELEASE cycles, plus one DONE cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int n = 1 << v.log2;
        int s = 0;
        int m = 0;
        for (int i = 0; i < n; i++) begin
            s += int'(v.bl[i]);
            if (int'(v.nw[i]) > m) m = int'(v.nw[i]);
        end
        r.exp_avg = s / n;
        r.exp_max = m;
        r.exp_lat = n * (v.k + 3) + 1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] l, input int k, input bit spam);
        vec_t v;
        v.log2 = l; v.k = k; v.spam = spam;
        v.bl = '0; v.nw = '0;
        v.exp_avg = 0; v.exp_max = 0; v.exp_lat = 0;
        return v;
    endfunction

    task automatic run_batch(input vec_t v, input string tag);
        int d0 = done_total;
        int r0 = rise_total;
        int lat = 0;
        bit seen = 1'b0;
        rbl = v.bl; rnw = v.nw; rk = v.k; ren = 1'b1; man_mode = 1'b0;
        ScanLog2 = v.log2;
        Start = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy_after_start"}, int'(Busy), 1);
                chk({tag, "_timeout_cleared"}, int'(Timeout), 0);
            end
            if (Done) begin
                seen = 1'b1;
                Start = 1'b0;
                break;
            end
            if (v.spam) begin
                Start = lat[0];
                ScanLog2 = 2'($urandom);
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_state_done"}, int'(StateOut), 4);
        chk({tag, "_blavg"}, int'(BLAvg), v.exp_avg);
        chk({tag, "_nwmax"}, int'(NWMax), v.exp_max);
        chk({tag, "_timeout"}, int'(Timeout), 0);
        tick();
        tick();
        chk({tag, "_idle_busy"}, int'(Busy), 0);
        chk({tag, "_done_pulses"}, done_total - d0, 1);
        chk({tag, "_scanstart_rises"}, rise_total - r0, 1 << v.log2);
        chk({tag, "_blavg_held"}, int'(BLAvg), v.exp_avg);
        last_avg = v.exp_avg;
        last_max = v.exp_max;
        ScanLog2 = 2'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int arm_cyc;
        int rty_cyc;
        int rel_ent;
        int d0;
        int exp_arm;
        int exp_rty;
        int exp_lat;
        bit reached;
        logic [2:0] pst;
        vec_t vr;

        // fixed vectors with hand-computed expectations
        vt[0] = mk(2'd0, 10, 1'b0);
        for (int i = 0; i < 8; i++) begin vt[0].bl[i] = 10'h155; vt[0].nw[i] = 4'd3; end
        vt[0].exp_avg = 'h155; vt[0].exp_max = 3; vt[0].exp_lat = 14;

        vt[1] = mk(2'd2, 3, 1'b0);
        vt[1].bl[0] = 10'd100; vt[1].bl[1] = 10'd101; vt[1].bl[2] = 10'd102; vt[1].bl[3] = 10'd104;
        vt[1].nw[0] = 4'd2; vt[1].nw[1] = 4'd7; vt[1].nw[2] = 4'd1; vt[1].nw[3] = 4'd5;
        vt[1].exp_avg = 101; vt[1].exp_max = 7; vt[1].exp_lat = 25;

        vt[2] = mk(2'd3, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin vt[2].bl[i] = 10'd1023; vt[2].nw[i] = 4'(2 * i); end
        vt[2].exp_avg = 1023; vt[2].exp_max = 14; vt[2].exp_lat = 33;

        vt[3] = mk(2'd1, 2, 1'b1);
        vt[3].bl[0] = 10'd7; vt[3].bl[1] = 10'd9;
        vt[3].nw[0] = 4'd4; vt[3].nw[1] = 4'd12;
        vt[3].exp_avg = 8; vt[3].exp_max = 12; vt[3].exp_lat = 11;

        for (int j = 4; j < 10; j++) begin
            vr = mk(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0);
            for (int i = 0; i < 8; i++) begin
                vr.bl[i] = 10'($urandom_range(0, 1023));
                vr.nw[i] = 4'($urandom_range(0, 15));
            end
            vt[j] = model(vr);
        end

        // reset state
        tick();
        tick();
        chk("rst_state", int'(StateOut), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_scanstart", int'(ScanStart), 0);
        chk("rst_timeout", int'(Timeout), 0);
        chk("rst_blavg", int'(BLAvg), 0);
        chk("rst_nwmax", int'(NWMax), 0);
        RST = 1'b0;
        tick();

        // Start together with ScanDone in IDLE; ScanDone still high on ARM entry
        man_mode = 1'b1; man_sd = 1'b1; man_bl = 10'h200; man_nw = 4'd9;
        ScanLog2 = 2'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("hand_arm_first", int'(StateOut), 1);
        tick();
        chk("hand_capture", int'(StateOut), 2);
        chk("hand_capture_ss", int'(ScanStart), 1);
        tick();
        chk("hand_release", int'(StateOut), 3);
        chk("hand_release_ss", int'(ScanStart), 0);
        man_sd = 1'b0;
        tick();
        chk("hand_done_state", int'(StateOut), 4);
        chk("hand_done_pulse", int'(Done), 1);
        chk("hand_blavg", int'(BLAvg), 'h200);
        chk("hand_nwmax", int'(NWMax), 9);
        tick();
        chk("hand_idle", int'(StateOut), 0);
        man_mode = 1'b0;

        // table-driven batches
        for (int j = 0; j < 10; j++) run_batch(vt[j], $sformatf("vec%0d", j));

        // timeout: responder silent
        ren = 1'b0;
        Start = 1'b1;
        lat = 0; arm_cyc = 0; rty_cyc = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            lat++;
            if (lat == 1) Start = 1'b0;
            if (StateOut == 3'd1) arm_cyc++;
            if (StateOut == 3'd6) rty_cyc++;
            if (Done) break;
        end
`ifdef TH_SCAN_SEQ_RETRY_EN
        exp_arm = 2 * (TMO + 1); exp_rty = 4; exp_lat = 2 * (TMO + 1) + 4 + 1;
`else
        exp_arm = TMO + 1; exp_rty = 0; exp_lat = TMO + 2;
`endif
        chk("tmo_latency", lat, exp_lat);
        chk("tmo_arm_cycles", arm_cyc, exp_arm);
        chk("tmo_retry_cycles", rty_cyc, exp_rty);
        chk("tmo_fail_state", int'(StateOut), 5);
        chk("tmo_done", int'(Done), 1);
        chk("tmo_flag", int'(Timeout), 1);
        chk("tmo_scanstart", int'(ScanStart), 0);
        chk("tmo_blavg_hold", int'(BLAvg), last_avg);
        chk("tmo_nwmax_hold", int'(NWMax), last_max);
        tick();
        chk("tmo_sticky", int'(Timeout), 1);
        chk("tmo_idle", int'(Busy), 0);

        // next Start clears the flag and runs normally
        run_batch(vt[0], "after_tmo");

        // reset during the third RELEASE of an 8-scan batch
        vr = mk(2'd3, 2, 1'b0);
        for (int i = 0; i < 8; i++) begin vr.bl[i] = 10'(50 + i); vr.nw[i] = 4'(i); end
        rbl = vr.bl; rnw = vr.nw; rk = 2; ren = 1'b1;
        ScanLog2 = 2'd3; Start = 1'b1;
        rel_ent = 0; reached = 1'b0; pst = 3'd0;
        for (int c = 0; c < 500; c++) begin
            tick();
            Start = 1'b0;
            if (StateOut == 3'd3 && pst != 3'd3) rel_ent++;
            pst = StateOut;
            if (rel_ent == 3) begin reached = 1'b1; break; end
        end
        chk("rst_mid_reached", int'(reached), 1);
        d0 = done_total;
        RST = 1'b1;
        #1;
        chk("rst_mid_state", int'(StateOut), 0);
        chk("rst_mid_busy", int'(Busy), 0);
        chk("rst_mid_scanstart", int'(ScanStart), 0);
        chk("rst_mid_done", int'(Done), 0);
        chk("rst_mid_timeout", int'(Timeout), 0);
        chk("rst_mid_blavg", int'(BLAvg), 0);
        chk("rst_mid_nwmax", int'(NWMax), 0);
        tick();
        tick();
        tick();
        chk("rst_mid_no_done", done_total - d0, 0);
        RST = 1'b0;
        ScanLog2 = 2'd0;
        run_batch(vt[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
